// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline stall/redirect bundle between the core pipeline (master)
// and the stall/redirect sequencer (slave).
interface pipe_stall_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
);
    logic              stallreq_id_i;
    logic              stallreq_ex_i;
    logic              branch_flag_i;
    logic [ADDR_W-1:0] branch_target_i;
    logic              flush_req_i;
    logic [ADDR_W-1:0] flush_target_i;
    logic [5:0]        stall_o;
    logic              branch_flag_o;
    logic [ADDR_W-1:0] branch_target_o;
    logic              flush_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic              stall_timeout_o;

    modport master (
        output stallreq_id_i, stallreq_ex_i, branch_flag_i, branch_target_i,
               flush_req_i, flush_target_i,
        input  stall_o, branch_flag_o, branch_target_o, flush_o,
               stall_cnt_o, stall_timeout_o
    );

    modport slave (
        input  stallreq_id_i, stallreq_ex_i, branch_flag_i, branch_target_i,
               flush_req_i, flush_target_i,
        output stall_o, branch_flag_o, branch_target_o, flush_o,
               stall_cnt_o, stall_timeout_o
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/redirect sequencer for the 6-stage core: merges stall requests,
// replays redirects held off by a stalled PC, runs flush sequences and a stall watchdog.
module pipe_stall_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int WDOG_MAX     = 255,
    parameter int CNT_W        = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    pipe_stall_ctrl_if.slave   bus
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              pend_v_q, pend_v_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic [ADDR_W-1:0] flush_tgt_q, flush_tgt_d;
    logic              flush_first_q, flush_first_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              timeout_q;

    logic [5:0]        stall;
    logic              stall_pc;
    logic              br_flag;
    logic [ADDR_W-1:0] br_tgt;
    logic              flush;

    // Outputs are forced low while reset is held, even for the combinational paths.
    always_comb begin
        stall = '0;
        if (reset_n && state_q != FLUSH) begin
            if (bus.stallreq_ex_i)
                stall = 6'b001111;
            else if (bus.stallreq_id_i)
                stall = 6'b000111;
        end
    end

    assign stall_pc = stall[0];

    always_comb begin
        state_d       = state_q;
        pend_v_d      = pend_v_q;
        pend_tgt_d    = pend_tgt_q;
        flush_tgt_d   = flush_tgt_q;
        flush_cnt_d   = flush_cnt_q;
        flush_first_d = 1'b0;
        br_flag       = 1'b0;
        br_tgt        = '0;
        flush         = 1'b0;

        case (state_q)
            RUN: begin
                if (bus.branch_flag_i) begin
                    if (!stall_pc) begin
                        br_flag = 1'b1;
                        br_tgt  = bus.branch_target_i;
                    end else begin
                        pend_tgt_d = bus.branch_target_i;
                        pend_v_d   = 1'b1;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall_pc && pend_v_q) begin
                    br_flag  = 1'b1;
                    br_tgt   = pend_tgt_q;
                    pend_v_d = 1'b0;
                    state_d  = RUN;
                end
                // Youngest redirect wins; one arriving on the replay cycle is held for the next.
                if (bus.branch_flag_i) begin
                    pend_tgt_d = bus.branch_target_i;
                    pend_v_d   = 1'b1;
                    state_d    = HOLD;
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (flush_first_q) begin
                    br_flag = 1'b1;
                    br_tgt  = flush_tgt_q;
                end
                if (flush_cnt_q == '0)
                    state_d = RUN;
                else
                    flush_cnt_d = flush_cnt_q - FC_W'(1);
            end
            default: state_d = RUN;
        endcase

        if (bus.flush_req_i) begin
            state_d       = FLUSH;
            pend_v_d      = 1'b0;
            flush_cnt_d   = FC_W'(FLUSH_CYCLES - 1);
            flush_tgt_d   = bus.flush_target_i;
            flush_first_d = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = '0;
        if (stall_pc)
            stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RUN;
            pend_v_q      <= 1'b0;
            pend_tgt_q    <= '0;
            flush_tgt_q   <= '0;
            flush_first_q <= 1'b0;
            flush_cnt_q   <= '0;
            stall_cnt_q   <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_v_q      <= pend_v_d;
            pend_tgt_q    <= pend_tgt_d;
            flush_tgt_q   <= flush_tgt_d;
            flush_first_q <= flush_first_d;
            flush_cnt_q   <= flush_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            if (stall_cnt_d == CNT_W'(WDOG_MAX))
                timeout_q <= 1'b1;
        end
    end

    assign bus.stall_o         = stall;
    assign bus.branch_flag_o   = reset_n & br_flag;
    assign bus.branch_target_o = reset_n ? br_tgt : '0;
    assign bus.flush_o         = reset_n & flush;
    assign bus.stall_cnt_o     = stall_cnt_q;
    assign bus.stall_timeout_o = timeout_q;

endmodule
